// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: issues single-outstanding instruction-memory reads
// from the PC, buffers returned words in a 2-entry queue for decode, and
// advances the PC on every accepted fetch. A flush drops queued data and
// discards any in-flight response.
// Optional build macro FETCH_PERF_CNT_EN adds saturating stall/flush counters.
module instr_fetch_unit #(
  parameter int ADDR_W  = 19,
  parameter int INSTR_W = 19
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [ADDR_W-1:0]  pc,
  output logic               pc_enable,
  input  logic               flush,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ready,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               ir_valid,
  input  logic               ir_ready,
  output logic [INSTR_W-1:0] ir,
  output logic [ADDR_W-1:0]  ir_pc
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [15:0]        perf_stall_cnt,
  output logic [15:0]        perf_flush_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DROP
  } state_t;

  state_t              state;
  state_t              state_next;
  logic                req_next;
  logic [ADDR_W-1:0]   addr_next;
  logic [1:0]          count;
  logic [1:0]          count_next;
  logic [INSTR_W-1:0]  q1_instr;
  logic [ADDR_W-1:0]   q1_pc;
  logic                resp;
  logic                push;
  logic                pop;

  // Handshake decode and queue occupancy for the coming edge
  always_comb begin
    ir_valid   = (count != 2'd0);
    resp       = (state == WAIT) && imem_ready;
    push       = resp && !flush;
    pop        = ir_valid && ir_ready && !flush;
    pc_enable  = push;
    count_next = count;
    if (flush) begin
      count_next = 2'd0;
    end else if (push && !pop) begin
      count_next = count + 2'd1;
    end else if (pop && !push) begin
      count_next = count - 2'd1;
    end
  end

  // Next-state and next-request logic; issue only when the queue keeps a free slot
  always_comb begin
    state_next = state;
    req_next   = imem_req;
    addr_next  = imem_addr;
    case (state)
      IDLE: begin
        if (!flush && (count != 2'd2)) begin
          req_next   = 1'b1;
          addr_next  = pc;
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (imem_ready) begin
          if (flush || (count_next == 2'd2)) begin
            req_next   = 1'b0;
            state_next = IDLE;
          end else begin
            addr_next = imem_addr + ADDR_W'(1);
          end
        end else if (flush) begin
          state_next = DROP;
        end
      end
      DROP: begin
        if (imem_ready) begin
          req_next   = 1'b0;
          state_next = IDLE;
        end
      end
      default: begin
        req_next   = 1'b0;
        state_next = IDLE;
      end
    endcase
  end

  // State and memory-request registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      imem_req  <= 1'b0;
      imem_addr <= '0;
    end else begin
      state     <= state_next;
      imem_req  <= req_next;
      imem_addr <= addr_next;
    end
  end

  // Two-entry queue: head lives in ir/ir_pc, second entry in q1_*.
  // A push lands in the head when the head is empty after this cycle's pop,
  // otherwise in the second slot; a pop at count 2 shifts q1 into the head.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count    <= 2'd0;
      ir       <= '0;
      ir_pc    <= '0;
      q1_instr <= '0;
      q1_pc    <= '0;
    end else begin
      count <= count_next;
      if (!flush) begin
        if (pop && (count == 2'd2)) begin
          ir    <= q1_instr;
          ir_pc <= q1_pc;
        end
        if (push) begin
          if ((count == 2'd0) || ((count == 2'd1) && pop)) begin
            ir    <= imem_rdata;
            ir_pc <= imem_addr;
          end else begin
            q1_instr <= imem_rdata;
            q1_pc    <= imem_addr;
          end
        end
      end
    end
  end

`ifdef FETCH_PERF_CNT_EN
  // Saturating performance counters for memory stalls and redirects
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_stall_cnt <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if (imem_req && !imem_ready && (perf_stall_cnt != '1)) begin
        perf_stall_cnt <= perf_stall_cnt + 16'd1;
      end
      if (flush && (perf_flush_cnt != '1)) begin
        perf_flush_cnt <= perf_flush_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Testbench for instr_fetch_unit: directed stimulus, a queue-based reference
// model compared every cycle, and hand-computed literal expectations.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [18:0] pc = '0;
  logic        pc_enable;
  logic        flush;
  logic        imem_req;
  logic [18:0] imem_addr;
  logic        imem_ready;
  logic [18:0] imem_rdata;
  logic        ir_valid;
  logic        ir_ready;
  logic [18:0] ir;
  logic [18:0] ir_pc;

  logic        pc_load;
  logic [18:0] pc_load_val;

  int checks = 0;
  int passes = 0;
  int pe_count = 0;
  int pe_base;
  bit chk_en = 1'b0;

  // Model state: one outstanding request, possibly doomed by a flush
  bit          m_busy;
  bit          m_doomed;
  logic [18:0] m_addr;
  logic [18:0] mq_i[$];
  logic [18:0] mq_p[$];

  instr_fetch_unit #(.ADDR_W(19), .INSTR_W(19)) dut (
    .clk        (clk),
    .rst        (rst),
    .pc         (pc),
    .pc_enable  (pc_enable),
    .flush      (flush),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ready (imem_ready),
    .imem_rdata (imem_rdata),
    .ir_valid   (ir_valid),
    .ir_ready   (ir_ready),
    .ir         (ir),
    .ir_pc      (ir_pc)
  );

  always #5 clk = ~clk;

  function automatic logic [18:0] mem_word(input logic [18:0] a);
    return a ^ 19'h2AAAA;
  endfunction

  assign imem_rdata = mem_word(imem_addr);

  // Program counter stand-in: redirect load wins over increment
  always @(posedge clk) begin
    if (pc_load) pc <= pc_load_val;
    else if (pc_enable) pc <= pc + 19'd1;
  end

  // Reference model update
  always @(posedge clk or posedge rst) begin
    int n0;
    if (rst) begin
      m_busy = 1'b0; m_doomed = 1'b0; m_addr = '0;
      mq_i.delete(); mq_p.delete();
    end else begin
      n0 = mq_i.size();
      if (flush) begin
        mq_i.delete(); mq_p.delete();
        if (m_busy) begin
          if (imem_ready) begin m_busy = 1'b0; m_doomed = 1'b0; end
          else m_doomed = 1'b1;
        end
      end else if (m_busy) begin
        if (n0 > 0 && ir_ready) begin void'(mq_i.pop_front()); void'(mq_p.pop_front()); end
        if (imem_ready) begin
          if (m_doomed) begin
            m_busy = 1'b0; m_doomed = 1'b0;
          end else begin
            mq_i.push_back(mem_word(m_addr));
            mq_p.push_back(m_addr);
            if (mq_i.size() < 2) m_addr = m_addr + 19'd1;
            else m_busy = 1'b0;
          end
        end
      end else begin
        if (n0 > 0 && ir_ready) begin void'(mq_i.pop_front()); void'(mq_p.pop_front()); end
        if (n0 < 2) begin m_busy = 1'b1; m_addr = pc; end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic compare_model();
    if (!rst) begin
      if (pc_enable === 1'b1) pe_count++;
      if (chk_en) begin
        check("m_req", {31'd0, imem_req}, {31'd0, m_busy});
        if (m_busy) check("m_addr", {13'd0, imem_addr}, {13'd0, m_addr});
        check("m_valid", {31'd0, ir_valid}, {31'd0, (mq_i.size() != 0)});
        check("m_pc_en", {31'd0, pc_enable},
              {31'd0, (m_busy && !m_doomed && imem_ready && !flush)});
        if (mq_i.size() != 0) begin
          check("m_ir", {13'd0, ir}, {13'd0, mq_i[0]});
          check("m_ir_pc", {13'd0, ir_pc}, {13'd0, mq_p[0]});
        end
      end
    end
  endtask

  // One clock: model compare on the falling edge, return 1 time unit after rise
  task automatic cyc();
    @(negedge clk);
    compare_model();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; flush = 1'b0; imem_ready = 1'b0; ir_ready = 1'b0;
    pc_load = 1'b1; pc_load_val = 19'h00010;
    #1;
    check("rst_req", {31'd0, imem_req}, 32'd0);
    check("rst_addr", {13'd0, imem_addr}, 32'd0);
    check("rst_valid", {31'd0, ir_valid}, 32'd0);
    check("rst_ir", {13'd0, ir}, 32'd0);
    check("rst_ir_pc", {13'd0, ir_pc}, 32'd0);
    check("rst_pc_en", {31'd0, pc_enable}, 32'd0);
    cyc();
    rst = 1'b0; pc_load = 1'b0; imem_ready = 1'b1; ir_ready = 1'b1; chk_en = 1'b1;

    // Streaming with zero-wait memory
    cyc();
    check("t1_req", {31'd0, imem_req}, 32'd1);
    check("t1_addr", {13'd0, imem_addr}, 32'h10);
    pe_base = pe_count;
    cyc();
    check("t1_pc0", {13'd0, ir_pc}, 32'h10);
    check("t1_ir0", {13'd0, ir}, 32'h2AABA);
    cyc();
    check("t1_pc1", {13'd0, ir_pc}, 32'h11);
    cyc();
    check("t1_pc2", {13'd0, ir_pc}, 32'h12);
    check("t1_pe", pe_count - pe_base, 32'd3);

    // Decode stalls: queue fills to two and fetching pauses
    ir_ready = 1'b0;
    cyc(); cyc(); cyc();
    check("t2_req", {31'd0, imem_req}, 32'd0);
    check("t2_valid", {31'd0, ir_valid}, 32'd1);
    check("t2_hold", {13'd0, ir_pc}, 32'h12);
    ir_ready = 1'b1;
    cyc();
    check("t2_pop", {13'd0, ir_pc}, 32'h13);
    check("t2_noreq", {31'd0, imem_req}, 32'd0);
    cyc();
    check("t2_resume", {31'd0, imem_req}, 32'd1);
    check("t2_raddr", {13'd0, imem_addr}, 32'h14);
    check("t2_empty", {31'd0, ir_valid}, 32'd0);
    cyc();
    check("t2_pc", {13'd0, ir_pc}, 32'h14);

    // Memory wait states: request held stable, one push
    imem_ready = 1'b0;
    pe_base = pe_count;
    check("t3_addr0", {13'd0, imem_addr}, 32'h15);
    for (int i = 1; i <= 3; i++) begin
      cyc();
      check("t3_req", {31'd0, imem_req}, 32'd1);
      check("t3_addr", {13'd0, imem_addr}, 32'h15);
      if (i == 3) imem_ready = 1'b1;
    end
    cyc();
    check("t3_pe", pe_count - pe_base, 32'd1);
    check("t3_ir_pc", {13'd0, ir_pc}, 32'h15);
    check("t3_next", {13'd0, imem_addr}, 32'h16);

    // Flush with the response still outstanding
    imem_ready = 1'b0; ir_ready = 1'b0; flush = 1'b1;
    pc_load = 1'b1; pc_load_val = 19'h00400;
    pe_base = pe_count;
    cyc();
    flush = 1'b0; pc_load = 1'b0;
    check("t4_empty", {31'd0, ir_valid}, 32'd0);
    check("t4_req", {31'd0, imem_req}, 32'd1);
    check("t4_addr", {13'd0, imem_addr}, 32'h16);
    cyc();
    imem_ready = 1'b1;
    cyc();
    check("t4_drop", {31'd0, imem_req}, 32'd0);
    check("t4_nopush", {31'd0, ir_valid}, 32'd0);
    check("t4_pe", pe_count - pe_base, 32'd0);
    cyc();
    check("t4_newreq", {31'd0, imem_req}, 32'd1);
    check("t4_newaddr", {13'd0, imem_addr}, 32'h400);

    // Flush coincident with the memory response
    cyc();
    check("t5_ir_pc", {13'd0, ir_pc}, 32'h400);
    flush = 1'b1; pc_load = 1'b1; pc_load_val = 19'h00800;
    pe_base = pe_count;
    cyc();
    flush = 1'b0; pc_load = 1'b0;
    check("t5_empty", {31'd0, ir_valid}, 32'd0);
    check("t5_req", {31'd0, imem_req}, 32'd0);
    check("t5_pe", pe_count - pe_base, 32'd0);
    cyc();
    check("t5_addr", {13'd0, imem_addr}, 32'h800);
    cyc(); cyc();
    check("t5_full", {31'd0, imem_req}, 32'd0);
    check("t5_head", {13'd0, ir_pc}, 32'h800);

    // Flush coincident with a pop at count 2
    flush = 1'b1; ir_ready = 1'b1; pc_load = 1'b1; pc_load_val = 19'h00C00;
    pe_base = pe_count;
    cyc();
    flush = 1'b0; pc_load = 1'b0;
    check("t5b_empty", {31'd0, ir_valid}, 32'd0);
    check("t5b_req", {31'd0, imem_req}, 32'd0);
    check("t5b_pe", pe_count - pe_base, 32'd0);
    cyc();
    check("t5b_addr", {13'd0, imem_addr}, 32'hC00);

    // Address wrap at the top of the space
    flush = 1'b1; pc_load = 1'b1; pc_load_val = 19'h7FFFF;
    cyc();
    flush = 1'b0; pc_load = 1'b0;
    cyc();
    check("t6_addr0", {13'd0, imem_addr}, 32'h7FFFF);
    cyc();
    check("t6_wrap", {13'd0, imem_addr}, 32'h00000);
    check("t6_head", {13'd0, ir_pc}, 32'h7FFFF);
    cyc();
    check("t6_head2", {13'd0, ir_pc}, 32'h00000);
    check("t6_ir", {13'd0, ir}, 32'h2AAAA);

    // Asynchronous reset in the middle of a request
    imem_ready = 1'b0; ir_ready = 1'b0;
    cyc();
    check("t7_pre_valid", {31'd0, ir_valid}, 32'd1);
    check("t7_pre_req", {31'd0, imem_req}, 32'd1);
    pc_load = 1'b1; pc_load_val = 19'h00123;
    #2;
    rst = 1'b1;
    #1;
    check("t7_req", {31'd0, imem_req}, 32'd0);
    check("t7_valid", {31'd0, ir_valid}, 32'd0);
    check("t7_addr", {13'd0, imem_addr}, 32'd0);
    check("t7_ir_pc", {13'd0, ir_pc}, 32'd0);
    cyc();
    rst = 1'b0; pc_load = 1'b0; imem_ready = 1'b1; ir_ready = 1'b1;
    cyc();
    check("t7_restart", {13'd0, imem_addr}, 32'h123);
    cyc();
    check("t7_head", {13'd0, ir_pc}, 32'h123);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
